// File: rtl/rx.sv
// Serial receiver: start bit, WIDTH data bits MSB first, stop bit; rx_po/rx_valid update at the stop sample edge.
// No backpressure on the line: a good frame arriving while rx_valid is unacknowledged is dropped with an rx_overrun pulse.
module rx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_si,
    input  logic             rx_ack,
    output logic [WIDTH-1:0] rx_po,
    output logic             rx_valid,
    output logic             rx_busy,
    output logic             rx_frame_err,
    output logic             rx_overrun
);

    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = 5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state, state_nxt;
    logic              sync1, s;
    logic              armed;
    logic [CW-1:0]     cnt, bitcnt;
    logic [WIDTH-1:0]  shreg;
    logic              tick;
    logic              detect, enter_data, data_smp, good_frame, bad_frame;

    assign tick = (cnt == '0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (armed && !s) state_nxt = (HALF > 0) ? START : DATA;
            START:   if (tick) state_nxt = s ? IDLE : DATA;
            DATA:    if (tick && bitcnt == CW'(1)) state_nxt = STOP;
            STOP:    if (tick) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        detect     = (state == IDLE) && armed && !s;
        // With a one-cycle bit time the detection edge is also the start sample.
        enter_data = (detect && HALF == 0) || (state == START && tick && !s);
        data_smp   = (state == DATA) && tick;
        good_frame = (state == STOP) && tick && s;
        bad_frame  = (state == STOP) && tick && !s;
        rx_busy    = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1        <= 1'b1;
            s            <= 1'b1;
            armed        <= 1'b1;
            cnt          <= '0;
            bitcnt       <= '0;
            shreg        <= '0;
            rx_po        <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            sync1        <= rx_si;
            s            <= sync1;
            rx_frame_err <= bad_frame;
            rx_overrun   <= good_frame && rx_valid && !rx_ack;

            // After a framing error the line must return high before a new start counts.
            if (bad_frame)
                armed <= 1'b0;
            else if (state == IDLE && s)
                armed <= 1'b1;

            if (enter_data) begin
                cnt    <= CW'(CLKS_PER_BIT - 1);
                bitcnt <= CW'(WIDTH);
            end else if (detect) begin
                cnt <= CW'(HALF - 1);
            end else if (data_smp) begin
                shreg  <= WIDTH'({shreg, s});
                bitcnt <= bitcnt - CW'(1);
                cnt    <= CW'(CLKS_PER_BIT - 1);
            end else if (state != IDLE && !tick) begin
                cnt <= cnt - CW'(1);
            end

            if (good_frame && (!rx_valid || rx_ack)) begin
                rx_po    <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ack) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rx.sv
// Bench for rx: directed frame table, hand-built corner sequences, and randomized line traffic against an event model.
module tb_rx;

    localparam int W = 8;
    localparam int N = 3200;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, si1, ack1, si8, ack8;
    logic [W-1:0] po1, po8;
    logic         v1, b1, e1, o1, v8, b8, e8, o8;

    rx #(.WIDTH(W), .CLKS_PER_BIT(1)) u1 (
        .clk(clk), .rst(rst), .rx_si(si1), .rx_ack(ack1), .rx_po(po1),
        .rx_valid(v1), .rx_busy(b1), .rx_frame_err(e1), .rx_overrun(o1));

    rx #(.WIDTH(W), .CLKS_PER_BIT(8)) u8 (
        .clk(clk), .rst(rst), .rx_si(si8), .rx_ack(ack8), .rx_po(po8),
        .rx_valid(v8), .rx_busy(b8), .rx_frame_err(e8), .rx_overrun(o8));

    int n_cmp, n_bad, wp;

    logic         line[N];
    logic         ackv[N];
    logic         rstv[N];
    logic [W-1:0] o_po[N];
    logic         o_v[N], o_b[N], o_e[N], o_o[N];
    logic [W-1:0] x_po[N];
    logic         x_v[N], x_b[N], x_e[N], x_o[N];
    int           ev_kind[N];
    logic [W-1:0] ev_word[N];

    typedef struct {
        logic [W-1:0] word;
        logic         stop;
        logic         ack;
        logic [W-1:0] po;
        logic         v;
        logic         err;
        logic         ovr;
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input int t, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %0h want %0h", name, t, act, exp);
        end
    endtask

    task automatic clear_stream();
        for (int i = 0; i < N; i++) begin
            line[i] = 1'b1; ackv[i] = 1'b0; rstv[i] = 1'b0;
        end
        wp = 0;
    endtask

    task automatic put_bits(input logic b, input int n);
        for (int i = 0; i < n; i++) begin
            if (wp < N) line[wp] = b;
            wp++;
        end
    endtask

    task automatic put_frame(input logic [W-1:0] w, input logic stop, input int cpb);
        put_bits(1'b0, cpb);
        for (int k = W - 1; k >= 0; k--) put_bits(w[k], cpb);
        put_bits(stop, cpb);
    endtask

    task automatic record(input int cpb, input int t);
        if (cpb == 1) begin
            o_po[t] = po1; o_v[t] = v1; o_b[t] = b1; o_e[t] = e1; o_o[t] = o1;
        end else begin
            o_po[t] = po8; o_v[t] = v8; o_b[t] = b8; o_e[t] = e8; o_o[t] = o8;
        end
    endtask

    // Edge -1 is a reset edge; line[t], ackv[t], rstv[t] are presented to edge t.
    task automatic play(input int cpb, input int len);
        @(negedge clk);
        rst = 1'b1; si1 = 1'b1; si8 = 1'b1; ack1 = 1'b0; ack8 = 1'b0;
        for (int t = 0; t < len; t++) begin
            @(negedge clk);
            if (t > 0) record(cpb, t - 1);
            rst = rstv[t];
            if (cpb == 1) begin si1 = line[t]; ack1 = ackv[t]; end
            else          begin si8 = line[t]; ack8 = ackv[t]; end
        end
        @(negedge clk);
        record(cpb, len - 1);
        rst = 1'b0; si1 = 1'b1; si8 = 1'b1; ack1 = 1'b0; ack8 = 1'b0;
    endtask

    function automatic int sum_arr(input int kind, input int a, input int b);
        int s = 0;
        for (int t = a; t <= b; t++) begin
            case (kind)
                0:       s += int'(o_b[t]);
                1:       s += int'(o_v[t]);
                default: s += int'(o_e[t]) + int'(o_o[t]);
            endcase
        end
        return s;
    endfunction

    // Synchronised line value seen by the receiver at edge d.
    function automatic logic sv(input int d, input int len);
        int idx = d - 2;
        if (idx < 0 || idx >= len) return 1'b1;
        return line[idx];
    endfunction

    task automatic model(input int cpb, input int len);
        int d, half, se;
        logic armed, valid;
        logic [W-1:0] w, po;
        half = cpb / 2;
        for (int t = 0; t < N; t++) begin ev_kind[t] = 0; ev_word[t] = '0; x_b[t] = 1'b0; end
        d = 0; armed = 1'b1;
        while (d < len) begin
            if (!armed) begin
                if (sv(d, len)) armed = 1'b1;
                d++;
            end else if (sv(d, len)) begin
                d++;
            end else if (half > 0 && sv(d + half, len)) begin
                for (int t = d; t < d + half && t < len; t++) x_b[t] = 1'b1;
                d = d + half + 1;
            end else begin
                w = '0;
                for (int k = 1; k <= W; k++) w = {w[W-2:0], sv(d + half + k * cpb, len)};
                se = d + half + (W + 1) * cpb;
                for (int t = d; t < se && t < len; t++) x_b[t] = 1'b1;
                if (se < len) begin
                    ev_kind[se] = sv(se, len) ? 1 : 2;
                    ev_word[se] = w;
                end
                if (!sv(se, len)) armed = 1'b0;
                d = se + 1;
            end
        end
        valid = 1'b0; po = '0;
        for (int t = 0; t < len; t++) begin
            x_e[t] = (ev_kind[t] == 2);
            x_o[t] = 1'b0;
            if (ev_kind[t] == 1) begin
                if (!valid || ackv[t]) begin po = ev_word[t]; valid = 1'b1; end
                else x_o[t] = 1'b1;
            end else if (ackv[t] && valid) begin
                valid = 1'b0;
            end
            x_v[t] = valid; x_po[t] = po;
        end
    endtask

    task automatic gen_random(input int cpb);
        int r;
        clear_stream();
        wp = 2;
        while (wp < N - 200) begin
            r = $urandom_range(0, 9);
            if (r == 0) begin
                put_bits(1'b0, $urandom_range(1, cpb));
                put_bits(1'b1, $urandom_range(1, 3 * cpb));
            end else begin
                put_frame(W'($urandom), (r != 9), cpb);
                if (r == 9) put_bits(1'b0, $urandom_range(0, 3 * cpb));
                put_bits(1'b1, $urandom_range(0, 2) * cpb + $urandom_range(0, 1));
            end
        end
        for (int t = 0; t < N; t++) ackv[t] = ($urandom_range(0, 3) == 0);
    endtask

    initial begin
        int e;
        n_cmp = 0; n_bad = 0;
        rst = 1'b1; si1 = 1'b1; si8 = 1'b1; ack1 = 1'b0; ack8 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_u1", 0, 32'({po1, v1, b1, e1, o1}), 32'd0);
        check("reset_u8", 0, 32'({po8, v8, b8, e8, o8}), 32'd0);
        rst = 1'b0;

        // Directed frames, 13 cycles apart, ack applied exactly at each stop sample edge.
        tbl[0] = '{8'h11, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'h22, 1'b1, 1'b0, 8'h11, 1'b1, 1'b0, 1'b1};
        tbl[2] = '{8'h33, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h5A, 1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{8'h44, 1'b1, 1'b0, 8'h33, 1'b1, 1'b0, 1'b1};
        tbl[5] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        tbl[6] = '{8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};
        clear_stream();
        for (int i = 0; i < 8; i++) begin
            e = 2 + i * 13;
            wp = e;
            put_frame(tbl[i].word, tbl[i].stop, 1);
            ackv[e + 11] = tbl[i].ack;
        end
        play(1, 2 + 8 * 13 + 5);
        for (int i = 0; i < 8; i++) begin
            e = 2 + i * 13;
            check("tbl_po",    e + 11, 32'(o_po[e + 11]), 32'(tbl[i].po));
            check("tbl_valid", e + 11, 32'(o_v[e + 11]),  32'(tbl[i].v));
            check("tbl_err",   e + 11, 32'(o_e[e + 11]),  32'(tbl[i].err));
            check("tbl_ovr",   e + 11, 32'(o_o[e + 11]),  32'(tbl[i].ovr));
            check("tbl_busy_before_stop", e + 10, 32'(o_b[e + 10]), 32'd1);
            check("tbl_busy_after_stop",  e + 11, 32'(o_b[e + 11]), 32'd0);
            check("tbl_pulse_one_cycle",  e + 12, 32'(o_e[e + 12] | o_o[e + 12]), 32'd0);
        end

        // Back-to-back 0xA5, 0x3C at full rate, ack one cycle after each valid.
        clear_stream();
        wp = 2;  put_frame(8'hA5, 1'b1, 1);
        wp = 12; put_frame(8'h3C, 1'b1, 1);
        ackv[14] = 1'b1; ackv[24] = 1'b1;
        play(1, 30);
        check("b2b_valid_pre1", 12, 32'(o_v[12]), 32'd0);
        check("b2b_valid1",     13, 32'(o_v[13]), 32'd1);
        check("b2b_po1",        13, 32'(o_po[13]), 32'hA5);
        check("b2b_busy2",      14, 32'(o_b[14]), 32'd1);
        check("b2b_ack1",       14, 32'(o_v[14]), 32'd0);
        check("b2b_valid_pre2", 22, 32'(o_v[22]), 32'd0);
        check("b2b_valid2",     23, 32'(o_v[23]), 32'd1);
        check("b2b_po2",        23, 32'(o_po[23]), 32'h3C);
        check("b2b_ack2",       24, 32'(o_v[24]), 32'd0);
        check("b2b_pulses",     29, sum_arr(2, 0, 29), 0);

        // Short low glitch on the 8x receiver is rejected at the start midpoint.
        clear_stream();
        line[2] = 1'b0; line[3] = 1'b0; line[4] = 1'b0;
        play(8, 40);
        check("glitch_busy_cycles", 39, sum_arr(0, 0, 39), 4);
        check("glitch_busy_last",    7, 32'(o_b[7]), 32'd1);
        check("glitch_idle",         8, 32'(o_b[8]), 32'd0);
        check("glitch_valid",       39, sum_arr(1, 0, 39), 0);
        check("glitch_pulses",      39, sum_arr(2, 0, 39), 0);

        // Stop bit forced low with the line held low afterwards, then a good 0x81.
        clear_stream();
        wp = 2; put_frame(8'h5A, 1'b0, 1); put_bits(1'b0, 5);
        wp = 25; put_frame(8'h81, 1'b1, 1);
        play(1, 46);
        check("ferr_pulse",       13, 32'(o_e[13]), 32'd1);
        check("ferr_pulse_count", 45, sum_arr(2, 0, 45), 1);
        check("ferr_no_restart",  26, sum_arr(0, 14, 26), 0);
        check("ferr_no_valid",    35, sum_arr(1, 0, 35), 0);
        check("ferr_next_valid",  36, 32'(o_v[36]), 32'd1);
        check("ferr_next_po",     36, 32'(o_po[36]), 32'h81);

        // One-cycle reset in the data bits of 0xF0, then a clean 0x0F.
        clear_stream();
        wp = 2;  put_frame(8'h11, 1'b1, 1);
        wp = 16; put_frame(8'hF0, 1'b1, 1);
        wp = 30; put_frame(8'h0F, 1'b1, 1);
        rstv[24] = 1'b1;
        play(1, 50);
        check("rst_pre_valid",    23, 32'(o_v[23]), 32'd1);
        check("rst_pre_busy",     23, 32'(o_b[23]), 32'd1);
        check("rst_outputs_zero", 24, 32'({o_po[24], o_v[24], o_b[24], o_e[24], o_o[24]}), 32'd0);
        check("rst_no_valid",     40, sum_arr(1, 24, 40), 0);
        check("rst_pulses",       49, sum_arr(2, 0, 49), 0);
        check("rst_next_valid",   41, 32'(o_v[41]), 32'd1);
        check("rst_next_po",      41, 32'(o_po[41]), 32'h0F);

        // Randomized traffic on both bit rates against the event model.
        for (int pass = 0; pass < 2; pass++) begin
            int cpb = (pass == 0) ? 1 : 8;
            gen_random(cpb);
            model(cpb, N);
            play(cpb, N);
            for (int t = 0; t < N; t++)
                check(cpb == 1 ? "rand_cpb1" : "rand_cpb8", t,
                      32'({o_po[t], o_v[t], o_b[t], o_e[t], o_o[t]}),
                      32'({x_po[t], x_v[t], x_b[t], x_e[t], x_o[t]}));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
